// File: rtl/mux8_arb_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way round-robin arbiter.
package mux8_arb_pkg;

   localparam int N_REQ = 8;
   localparam int PTR_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = idx | PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set req bit in order ptr+1 .. ptr+8 (mod 8).
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any,
   output logic [PTR_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   logic [N_REQ-1:0] w_rot;
   logic [N_REQ-1:0] w_rot_oh;

   // Rotate so bit 0 is the highest-priority requester, isolate the lowest set bit, rotate back.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign w_rot[gi]  = req[ptr + PTR_W'(gi + 1)];
         assign onehot[gi] = w_rot_oh[PTR_W'(gi) - ptr - PTR_W'(1)];
      end
   endgenerate

   assign w_rot_oh = w_rot & (~w_rot + N_REQ'(1));
   assign any      = |req;
   assign idx      = onehot_to_idx(onehot);

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin packet arbiter driving the one-hot select of an 8-way AND-OR mux.
// Optional stall timeout with forced release when ARB_TIMEOUT_EN is defined.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int DW = 32
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 255
`endif
)
(
   input  logic                clk,
   input  logic                nreset,
   input  logic [N_REQ-1:0]    in_valid,
   input  logic [N_REQ-1:0]    in_last,
   input  logic [N_REQ*DW-1:0] in_data,
   output logic [N_REQ-1:0]    in_ready,
   output logic                out_valid,
   output logic                out_last,
   output logic [DW-1:0]       out_data,
   input  logic                out_ready,
   output logic [N_REQ-1:0]    grant,
   output logic                busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                timeout_err
`endif
);

   arb_state_e       r_state, w_state_next;
   logic [N_REQ-1:0] r_grant, w_grant_next;
   logic [PTR_W-1:0] r_ptr, w_ptr_next;

   logic             w_pick_any;
   logic [PTR_W-1:0] w_pick_idx;
   logic [N_REQ-1:0] w_pick_onehot;

   logic             w_out_valid;
   logic             w_out_last;
   logic             w_xfer;
   logic             w_release;
   logic             w_timeout_hit;
   logic             w_arb;

   logic [DW-1:0]    w_data_terms [N_REQ];
   logic [DW-1:0]    w_data_mux;

   rr_pick8 u_pick (
      .req    (in_valid),
      .ptr    (r_ptr),
      .any    (w_pick_any),
      .idx    (w_pick_idx),
      .onehot (w_pick_onehot)
   );

   // AND-OR select mux driven directly by the registered grant.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mux
         assign w_data_terms[gi] = in_data[gi*DW +: DW] & {DW{r_grant[gi]}};
      end
   endgenerate

   always_comb begin
      w_data_mux = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_data_mux = w_data_mux | w_data_terms[i];
      end
   end

   assign w_out_valid = |(r_grant & in_valid);
   assign w_out_last  = |(r_grant & in_last);
   assign w_xfer      = w_out_valid & out_ready;
   assign w_release   = (r_state == LOCK) & w_xfer & w_out_last;
   assign w_arb       = (r_state == IDLE) | w_release | w_timeout_hit;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_timeout_err;

   // The stall that would bring the count to TIMEOUT is the one that forces release.
   assign w_timeout_hit = (r_state == LOCK) & ~w_xfer & (r_stall_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_stall_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout_hit;
         if (w_arb || w_xfer) begin
            r_stall_cnt <= '0;
         end else if (r_state == LOCK) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= PTR_W'(N_REQ - 1);
      end else begin
         r_state <= w_state_next;
         r_grant <= w_grant_next;
         r_ptr   <= w_ptr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_ptr_next   = r_ptr;
      if (w_arb) begin
         if (w_pick_any) begin
            w_state_next = LOCK;
            w_grant_next = w_pick_onehot;
            w_ptr_next   = w_pick_idx;
         end else begin
            w_state_next = IDLE;
            w_grant_next = '0;
         end
      end
   end

   always_comb begin
      grant     = r_grant;
      busy      = (r_state == LOCK);
      out_valid = w_out_valid;
      out_last  = w_out_last;
      out_data  = w_data_mux;
      in_ready  = r_grant & {N_REQ{out_ready}};
   end

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!nreset) $onehot0(r_grant));

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed vector table, async reset, random traffic vs. model.
module tb_mux8_rr_arbiter;

   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            nreset;
   logic [7:0]      in_valid, in_last, in_ready;
   logic [8*DW-1:0] in_data;
   logic            out_valid, out_last, out_ready, busy;
   logic [DW-1:0]   out_data;
   logic [7:0]      grant;
`ifdef ARB_TIMEOUT_EN
   logic            timeout_err;
`endif

   logic [DW-1:0]   d [8];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = d[i];
   end

   mux8_rr_arbiter #(.DW(DW)) dut (
      .clk         (clk),
      .nreset      (nreset),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .grant       (grant),
      .busy        (busy)
`ifdef ARB_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   typedef struct {
      logic       rst;
      logic [7:0] v;
      logic [7:0] l;
      logic       rdy;
      logic [7:0] g;
      logic       ov;
      logic       bz;
   } vec_t;

   vec_t tbl[$];

   function automatic void addv(logic rst, logic [7:0] v, logic [7:0] l, logic rdy,
                                logic [7:0] g, logic ov, logic bz);
      vec_t e;
      e.rst = rst; e.v = v; e.l = l; e.rdy = rdy; e.g = g; e.ov = ov; e.bz = bz;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model state: current owner (-1 = idle) and last-served index.
   int          m_own;
   int          m_ptr;
   logic        g_pres [8];
   logic        g_last [8];
   int          g_left [8];

   function automatic int pick(input logic [7:0] v, input int ptr);
      for (int k = 1; k <= 8; k++) begin
         if (v[(ptr + k) % 8]) return (ptr + k) % 8;
      end
      return -1;
   endfunction

   initial begin
      logic [7:0]  eg;
      logic [7:0]  vsnap;
      logic [DW-1:0] ed;
      logic        el, eov;
      int          gi_idx;

      nreset = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) d[i] = 32'hC0DE_0000 + i;
      repeat (2) @(posedge clk);
      #1 nreset = 1'b1;

      // test 1: idle, then single request; owner alone re-wins on its own release beat
      addv(0, 8'h00, 8'hFF, 1, 8'h00, 0, 0);
      addv(0, 8'h08, 8'hFF, 1, 8'h00, 0, 0);
      addv(0, 8'h08, 8'hFF, 1, 8'h08, 1, 1);
      addv(0, 8'h00, 8'hFF, 1, 8'h08, 0, 1);
      // test 2: all requesting single-beat packets, rotation without bubbles
      addv(1, 8'hFF, 8'hFF, 1, 8'h00, 0, 0);
      addv(0, 8'hFF, 8'hFF, 1, 8'h00, 0, 0);
      for (int k = 0; k < 9; k++) addv(0, 8'hFF, 8'hFF, 1, 8'(1 << (k % 8)), 1, 1);
      addv(0, 8'h00, 8'hFF, 1, 8'h02, 0, 1);
      // test 3: 4-beat packet from req 2 while req 5 waits
      addv(1, 8'h00, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h04, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h04, 8'h00, 1, 8'h04, 1, 1);
      addv(0, 8'h24, 8'h00, 1, 8'h04, 1, 1);
      addv(0, 8'h24, 8'h00, 1, 8'h04, 1, 1);
      addv(0, 8'h24, 8'h04, 1, 8'h04, 1, 1);
      addv(0, 8'h20, 8'h20, 1, 8'h20, 1, 1);
      addv(0, 8'h00, 8'h00, 1, 8'h20, 0, 1);
      // test 4: backpressure mid-packet
      addv(1, 8'h00, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h01, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h01, 8'h00, 1, 8'h01, 1, 1);
      addv(0, 8'h01, 8'h00, 0, 8'h01, 1, 1);
      addv(0, 8'h01, 8'h00, 0, 8'h01, 1, 1);
      addv(0, 8'h01, 8'h00, 1, 8'h01, 1, 1);
      addv(0, 8'h01, 8'h01, 1, 8'h01, 1, 1);
      addv(0, 8'h00, 8'h00, 1, 8'h01, 0, 1);
      // test 5: async reset mid-packet, pointer back to 7
      addv(1, 8'h00, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h81, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h81, 8'h00, 1, 8'h01, 1, 1);
      addv(0, 8'h81, 8'h00, 1, 8'h01, 1, 1);
      addv(1, 8'h81, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h81, 8'h00, 1, 8'h00, 0, 0);
      addv(0, 8'h81, 8'h00, 1, 8'h01, 1, 1);
      addv(0, 8'h00, 8'h00, 1, 8'h01, 0, 1);

      foreach (tbl[n]) begin
         nreset    = ~tbl[n].rst;
         in_valid  = tbl[n].v;
         in_last   = tbl[n].l;
         out_ready = tbl[n].rdy;
         @(negedge clk);
         ed = '0;
         for (int i = 0; i < 8; i++) if (tbl[n].g[i]) ed = d[i];
         chk($sformatf("vec%0d grant", n), 64'(grant), 64'(tbl[n].g));
         chk($sformatf("vec%0d out_valid", n), 64'(out_valid), 64'(tbl[n].ov));
         chk($sformatf("vec%0d busy", n), 64'(busy), 64'(tbl[n].bz));
         chk($sformatf("vec%0d in_ready", n), 64'(in_ready), 64'(tbl[n].g & {8{tbl[n].rdy}}));
         chk($sformatf("vec%0d out_data", n), 64'(out_data), 64'(ed));
         chk($sformatf("vec%0d out_last", n), 64'(out_last), 64'(|(tbl[n].g & tbl[n].l)));
         $display("vec %0d: valid=%h last=%h rdy=%0d -> grant=%h ov=%0d busy=%0d",
                  n, tbl[n].v, tbl[n].l, tbl[n].rdy, grant, out_valid, busy);
         @(posedge clk);
         #1;
      end

      // random traffic against the packet-level model
      nreset = 1'b0; in_valid = '0; in_last = '0;
      m_own = -1; m_ptr = 7;
      for (int i = 0; i < 8; i++) begin g_pres[i] = 1'b0; g_last[i] = 1'b0; g_left[i] = 0; end
      @(posedge clk);
      #1 nreset = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < 8; i++) begin
            in_valid[i] = g_pres[i];
            in_last[i]  = g_last[i];
         end
         out_ready = ($urandom % 4) != 0;
         @(negedge clk);
         eg  = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
         eov = (m_own >= 0) ? in_valid[m_own] : 1'b0;
         el  = (m_own >= 0) ? in_last[m_own]  : 1'b0;
         ed  = (m_own >= 0) ? d[m_own] : '0;
         chk("rnd grant", 64'(grant), 64'(eg));
         chk("rnd out_valid", 64'(out_valid), 64'(eov));
         chk("rnd out_last", 64'(out_last), 64'(el));
         chk("rnd out_data", 64'(out_data), 64'(ed));
         chk("rnd in_ready", 64'(in_ready), 64'(eg & {8{out_ready}}));
         chk("rnd busy", 64'(busy), 64'(m_own >= 0));
         chk("rnd onehot0", 64'($onehot0(grant)), 64'(1));
`ifdef ARB_TIMEOUT_EN
         chk("rnd timeout_err", 64'(timeout_err), 64'(0));
`endif
         if (eov && out_ready)
            $display("beat %0d: req=%0d data=%h last=%0d", cyc, m_own, ed, el);
         @(posedge clk);
         #1;
         vsnap = in_valid;
         if (m_own < 0) begin
            m_own = pick(vsnap, m_ptr);
         end else if (vsnap[m_own] && out_ready) begin
            g_pres[m_own] = 1'b0;
            if (in_last[m_own]) m_own = pick(vsnap, m_ptr);
         end
         if (m_own >= 0) m_ptr = m_own;
         for (int i = 0; i < 8; i++) begin
            if (!g_pres[i]) begin
               d[i] = $urandom;
               g_last[i] = $urandom % 2;
               if ($urandom % 2) begin
                  if (g_left[i] == 0) g_left[i] = 1 + $urandom % 4;
                  g_last[i] = (g_left[i] == 1);
                  g_left[i]--;
                  g_pres[i] = 1'b1;
               end
            end
         end
      end

`ifdef ARB_TIMEOUT_EN
      begin
         int pulses;
         int first_at;
         pulses = 0; first_at = -1;
         nreset = 1'b0; in_valid = 8'h03; in_last = 8'h00; out_ready = 1'b0;
         @(posedge clk);
         #1 nreset = 1'b1;
         @(posedge clk);
         #1;
         for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (timeout_err) begin
               pulses++;
               if (first_at < 0) first_at = i;
            end
            if (i == 1) chk("to grant before", 64'(grant), 64'(8'h01));
            @(posedge clk);
            #1;
         end
         chk("to pulses", 64'(pulses), 64'(1));
         chk("to first_at", 64'(first_at), 64'(256));
         chk("to grant after", 64'(grant), 64'(8'h02));
         $display("timeout: pulses=%0d first_at=%0d grant=%h", pulses, first_at, grant);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and packet sequencer for the 8-way one-hot AND-OR select mux in the common library.
- Shares one DW-wide output channel between 8 valid/ready requesters.
- Drives a registered one-hot grant that the mux uses as sel7..sel0.
- Holds ownership for a full multi-beat packet, delimited by last, then rotates priority.

Parameters:
DW, 32, data width of each requester and of the output
TIMEOUT, 255, stall-cycle limit before forced release; used only with ARB_TIMEOUT_EN

Ports:
clk  input  1  clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
in_valid  input  8  per-requester beat valid
in_last  input  8  per-requester last beat of packet
in_data  input  8*DW  requester i at [i*DW +: DW]
in_ready  output  8  per-requester beat accepted
out_valid  output  1  output beat valid
out_last  output  1  output last beat
out_data  output  DW  muxed data of granted requester
out_ready  input  1  downstream accept
grant  output  8  registered one-hot owner; all zero when idle; feeds mux sel lines
busy  output  1  high while a packet is locked

Behaviour:
- Reset values (async on nreset low): grant=0, busy=0, state=IDLE, ptr=7 so requester 0 has first priority.
  - out_valid=0 and in_ready=0 follow from grant=0.
- State machine, states IDLE and LOCK.
  - Datapath is combinational from registered grant: out_data/out_last = one-hot mux of in_data/in_last by grant.
  - out_valid = |(grant & in_valid).
  - in_ready = grant & {8{out_ready}}.
  - Transfer beat: out_valid & out_ready.
- Arbitration instant: state IDLE, or state LOCK on a transfer beat with out_last=1 (release beat).
  - Winner = first i in order ptr+1 .. ptr+8 (mod 8) with in_valid[i]=1. Picker is combinational; the result is registered.
  - Winner found: next grant=onehot(winner), ptr<=winner, state LOCK, busy=1.
  - No winner: next grant=0, state IDLE, busy=0. ptr is unchanged.
- Latency:
  - First beat is presented 1 cycle after in_valid rises from IDLE.
  - On release, the next packet is granted back-to-back with no bubble.
- LOCK with a non-last transfer: grant held. LOCK with no transfer: grant held indefinitely.
  - If the granted requester drops in_valid mid-packet, out_valid goes low and the lock remains.
- A requester asserting in_valid for the next packet on its own release beat loses to any other valid requester (rotation). It wins only if it is alone.
- Requesters must hold in_valid, in_data and in_last stable until in_ready. Non-granted in_valid has no effect on the output.
- Single-beat packet: in_last=1 on the first beat means grant for 1 transfer cycle only.
- Reset mid-packet: the packet is abandoned and grant returns to 0 immediately. The downstream must tolerate the truncated packet.
- grant is never multi-hot. This is a required assertion.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - Adds output timeout_err (1 bit) and an 8-bit-minimum stall counter.
  - Counter clears on any transfer or on entering LOCK, and increments each LOCK cycle without a transfer.
  - Reaching TIMEOUT forces a release (treated as a release beat: re-arbitrate, owner loses priority).
  - timeout_err pulses high for 1 cycle; it resets to 0.
- Not defined: no port and no counter; lock is held indefinitely.

Decomposition:
- Package mux8_arb_pkg:
  - N_REQ=8, PTR_W=3.
  - State enum {IDLE, LOCK}.
  - onehot-to-index function.
- One natural sub-module: rr_pick8, a combinational rotate-by-ptr priority picker.
  - Inputs: req[7:0], ptr[2:0]. Outputs: any, idx[2:0], onehot[7:0].
- The datapath mux is instantiated in the top level, not duplicated.

Test Plan:
1. Reset release with in_valid=8'h00 -> grant=0, busy=0, out_valid=0. Then in_valid=8'h08 -> next cycle grant=8'h08, out_data=in_data[3].
2. in_valid=8'hFF, 1-beat packets, out_ready=1 -> grant sequence 01,02,04,...,80,01 with one beat per cycle and no bubbles.
3. Req 2 sends a 4-beat packet while req 5 is valid from beat 2 -> grant=8'h04 for 4 transfers, then 8'h20 on the cycle after the last beat.
4. out_ready toggles 1,0,0,1 mid-packet -> grant stable; in_ready[owner] mirrors out_ready; no beat is lost or duplicated.
5. Assert nreset low mid-packet -> grant=0 and busy=0 asynchronously. After release, ptr=7, so requester 0 wins first among 8'h81.
6. With ARB_TIMEOUT_EN and TIMEOUT=4: owner stalls with out_ready=0 -> after 4 stall cycles timeout_err pulses once and grant moves to the next valid requester.
